// File: rtl/hash_update_writer.sv
// Final digest stage: adds the working variables to H(i-1), keeps H(i)
// and writes the eight result words to memory one per cycle.
module hash_update_writer #(
  parameter int HASH_LENGTH = 8,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        hash_vector_complete,
  input  logic [32*HASH_LENGTH-1:0]   hash_vector,
  input  logic [32*HASH_LENGTH-1:0]   prev_hash_vector,
  input  logic [ADDR_WIDTH-1:0]       output_base_addr,
  output logic                        mem_write_en,
  output logic [ADDR_WIDTH-1:0]       mem_address,
  output logic [31:0]                 mem_write_data,
  output logic [32*HASH_LENGTH-1:0]   updated_hash_vector,
  output logic                        busy,
  output logic                        write_complete
);

  localparam int IW = $clog2(HASH_LENGTH + 1);
  localparam int SW = (HASH_LENGTH > 1) ? $clog2(HASH_LENGTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(HASH_LENGTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  logic                      wen_d;
  logic [ADDR_WIDTH-1:0]     addr_d;
  logic [31:0]               data_d;
  logic [32*HASH_LENGTH-1:0] uhv_d;
  logic                      busy_d;
  logic                      wc_d;

  logic [32*HASH_LENGTH-1:0] sum;
  logic [31:0]               words [HASH_LENGTH];

  // Carries are dropped per word: each lane is an independent mod-2^32 add
  for (genvar g = 0; g < HASH_LENGTH; g++) begin : g_lane
    assign sum[g*32 +: 32] = prev_hash_vector[g*32 +: 32]
                           + hash_vector[g*32 +: 32];
    assign words[g] = updated_hash_vector[g*32 +: 32];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (hash_vector_complete) state_d = WRITE;
        WRITE:   if (idx_q == LAST) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wen_d  = 1'b0;
    addr_d = mem_address;
    data_d = mem_write_data;
    uhv_d  = updated_hash_vector;
    idx_d  = idx_q;
    busy_d = 1'b0;
    wc_d   = 1'b0;
    if (!enable) begin
      idx_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hash_vector_complete) begin
            uhv_d  = sum;
            idx_d  = '0;
            busy_d = 1'b1;
          end
        end
        WRITE: begin
          if (idx_q < LAST) begin
            wen_d  = 1'b1;
            addr_d = output_base_addr + ADDR_WIDTH'(idx_q);
            data_d = words[idx_q[SW-1:0]];
            idx_d  = idx_q + 1'b1;
            busy_d = 1'b1;
          end else begin
            wc_d = 1'b1;
          end
        end
        DONE:    wc_d = 1'b1;
        default: idx_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q               <= '0;
      mem_write_en        <= 1'b0;
      mem_address         <= '0;
      mem_write_data      <= '0;
      updated_hash_vector <= '0;
      busy                <= 1'b0;
      write_complete      <= 1'b0;
    end else begin
      idx_q               <= idx_d;
      mem_write_en        <= wen_d;
      mem_address         <= addr_d;
      mem_write_data      <= data_d;
      updated_hash_vector <= uhv_d;
      busy                <= busy_d;
      write_complete      <= wc_d;
    end
  end

endmodule

// File: tb/tb_hash_update_writer.sv
// Scoreboard bench for hash_update_writer: expected writes are queued at
// start and popped by a negedge monitor as the DUT writes them.
module tb_hash_update_writer;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         hash_vector_complete;
  logic [255:0] hash_vector;
  logic [255:0] prev_hash_vector;
  logic [15:0]  output_base_addr;
  logic         mem_write_en;
  logic [15:0]  mem_address;
  logic [31:0]  mem_write_data;
  logic [255:0] updated_hash_vector;
  logic         busy;
  logic         write_complete;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  int           wr_count = 0;
  logic [255:0] exp_uhv;

  hash_update_writer #(.HASH_LENGTH(8), .ADDR_WIDTH(16)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .hash_vector_complete(hash_vector_complete),
    .hash_vector(hash_vector),
    .prev_hash_vector(prev_hash_vector),
    .output_base_addr(output_base_addr),
    .mem_write_en(mem_write_en),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .updated_hash_vector(updated_hash_vector),
    .busy(busy),
    .write_complete(write_complete)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset === 1'b1 && mem_write_en === 1'b1) begin
      exp_t e;
      wr_count++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%h data=%h", mem_address,
                 mem_write_data);
      end else begin
        e = sb.pop_front();
        if (mem_address !== e.a || mem_write_data !== e.d) begin
          fails++;
          $display("FAIL write got %h/%h want %h/%h", mem_address,
                   mem_write_data, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // Returns to IDLE, then starts; on return we sit 1 ns after the start edge.
  task automatic start_burst(input logic [255:0] p, input logic [255:0] h,
                             input logic [15:0] base, input int nwords);
    logic [31:0] w;
    enable = 1'b0;
    @(posedge clock); #1;
    prev_hash_vector     = p;
    hash_vector          = h;
    output_base_addr     = base;
    enable               = 1'b1;
    hash_vector_complete = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = p[i*32 +: 32] + h[i*32 +: 32];
      exp_uhv[i*32 +: 32] = w;
      if (i < nwords) sb.push_back('{a: 16'(base + 16'(i)), d: w});
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset                = 1'b0;
    enable               = 1'($urandom);
    hash_vector_complete = 1'($urandom);
    hash_vector          = {8{$urandom}};
    prev_hash_vector     = {8{$urandom}};
    output_base_addr     = 16'($urandom);
    #1;
    tests++;
    if ({mem_write_en, busy, write_complete} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags got %b want 000",
               {mem_write_en, busy, write_complete});
    end
    tests++;
    if (mem_address !== 16'h0 || mem_write_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_addr_data got %h/%h want 0/0", mem_address,
               mem_write_data);
    end
    tests++;
    if (updated_hash_vector !== 256'h0) begin
      fails++;
      $display("FAIL reset_uhv got %h want 0", updated_hash_vector);
    end
    @(posedge clock); #1;
    enable = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hash_vector_complete = 1'($urandom);
      @(posedge clock); #1;
    end
    tests++;
    if (wr_count !== 0) begin
      fails++;
      $display("FAIL reset_idle_writes got %0d want 0", wr_count);
    end
  endtask

  task automatic test_nominal();
    logic [255:0] p, h, want;
    for (int i = 0; i < 8; i++) begin
      p[i*32 +: 32]    = 32'hFFFFFFF0 + 32'(i);
      h[i*32 +: 32]    = 32'h00000020;
      want[i*32 +: 32] = 32'h00000010 + 32'(i);
    end
    start_burst(p, h, 16'h0100, 8);
    tests++;
    if (updated_hash_vector !== want) begin
      fails++;
      $display("FAIL nom_uhv got %h want %h", updated_hash_vector, want);
    end
    tests++;
    if (busy !== 1'b1 || mem_write_en !== 1'b0) begin
      fails++;
      $display("FAIL nom_e0 busy/wen got %b%b want 10", busy, mem_write_en);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      tests++;
      if (mem_write_en !== 1'b1 || busy !== 1'b1) begin
        fails++;
        $display("FAIL nom_wen e%0d got %b%b want 11", k + 1, mem_write_en,
                 busy);
      end
    end
    @(posedge clock); #1;
    tests++;
    if ({mem_write_en, busy, write_complete} !== 3'b001) begin
      fails++;
      $display("FAIL nom_e9 got %b want 001",
               {mem_write_en, busy, write_complete});
    end
    tests++;
    if (sb.size() != 0 || wr_count != 8) begin
      fails++;
      $display("FAIL nom_count got %0d left %0d want 8 left 0", wr_count,
               sb.size());
    end
  endtask

  task automatic test_no_retrigger();
    int base_cnt = wr_count;
    logic [255:0] p, h;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
    end
    tests++;
    if (write_complete !== 1'b1 || wr_count != base_cnt) begin
      fails++;
      $display("FAIL retrig_hold wc=%b writes=%0d want 1 %0d",
               write_complete, wr_count, base_cnt);
    end
    enable = 1'b0;
    @(posedge clock); #1;
    tests++;
    if (write_complete !== 1'b0) begin
      fails++;
      $display("FAIL retrig_clear wc got %b want 0", write_complete);
    end
    p = {8{$urandom}};
    h = {8{$urandom}};
    p[31:0] = 32'hFFFFFFFF;
    h[31:0] = 32'h00000002;
    start_burst(p, h, 16'h2000, 8);
    tests++;
    if (updated_hash_vector !== exp_uhv || updated_hash_vector[31:0] !== 32'h1) begin
      fails++;
      $display("FAIL restart_uhv got %h want %h", updated_hash_vector,
               exp_uhv);
    end
    repeat (9) @(posedge clock);
    #1;
    tests++;
    if (write_complete !== 1'b1 || sb.size() != 0 ||
        wr_count != base_cnt + 8) begin
      fails++;
      $display("FAIL restart_done wc=%b writes=%0d want 1 %0d",
               write_complete, wr_count - base_cnt, 8);
    end
  endtask

  task automatic test_addr_wrap();
    int base_cnt = wr_count;
    start_burst({8{32'h01020304}}, {8{32'h10203040}}, 16'hFFFC, 8);
    repeat (9) @(posedge clock);
    #1;
    tests++;
    if (sb.size() != 0 || wr_count != base_cnt + 8) begin
      fails++;
      $display("FAIL wrap_count got %0d left %0d want 8 left 0",
               wr_count - base_cnt, sb.size());
    end
    tests++;
    if (mem_address !== 16'h0003) begin
      fails++;
      $display("FAIL wrap_last got %h want 0003", mem_address);
    end
  endtask

  task automatic test_abort();
    int base_cnt = wr_count;
    start_burst({8{$urandom}}, {8{$urandom}}, 16'h0400, 4);
    repeat (4) @(posedge clock);
    #1;
    enable = 1'b0;
    @(posedge clock); #1;
    tests++;
    if ({mem_write_en, busy, write_complete} !== 3'b000) begin
      fails++;
      $display("FAIL abort_flags got %b want 000",
               {mem_write_en, busy, write_complete});
    end
    repeat (5) @(posedge clock);
    #1;
    tests++;
    if (updated_hash_vector !== exp_uhv) begin
      fails++;
      $display("FAIL abort_uhv got %h want %h", updated_hash_vector, exp_uhv);
    end
    tests++;
    if (wr_count != base_cnt + 4 || sb.size() != 0 || write_complete !== 1'b0) begin
      fails++;
      $display("FAIL abort_count got %0d wc=%b want 4 0", wr_count - base_cnt,
               write_complete);
    end
  endtask

  task automatic test_async_reset();
    int base_cnt = wr_count;
    start_burst({8{$urandom}}, {8{$urandom}}, 16'h0800, 6);
    repeat (6) @(posedge clock);
    #6;
    reset = 1'b0;
    #1;
    tests++;
    if ({mem_write_en, busy, write_complete} !== 3'b000 ||
        updated_hash_vector !== 256'h0 || mem_address !== 16'h0) begin
      fails++;
      $display("FAIL areset got wen=%b busy=%b addr=%h want 0 0 0",
               mem_write_en, busy, mem_address);
    end
    hash_vector_complete = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    tests++;
    if (wr_count != base_cnt + 6 || sb.size() != 0) begin
      fails++;
      $display("FAIL areset_residual got %0d left %0d want 6 left 0",
               wr_count - base_cnt, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_no_retrigger();
    test_addr_wrap();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hash_update_writer.md
# hash_update_writer

Final stage of the per-block digest path, directly downstream of the hash vector assembly stage. It consumes the assembled 256-bit working-variable vector and its completion flag. It adds the vector word-wise (mod 2^32) to the previous intermediate hash, registers the updated hash for the next message block, and writes the eight result words to output memory one word per cycle.

## Interface

Parameters:
- HASH_LENGTH, 8, number of 32-bit words per hash; word i occupies bits [32i+31:32i] of every 256-bit vector.
- ADDR_WIDTH, 16, output memory address width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  run qualifier; low aborts and returns to IDLE.
- hash_vector_complete  input  1  level flag from the assembly stage: hash_vector is valid.
- hash_vector  input  256  working variables a..h (word 0 = a).
- prev_hash_vector  input  256  intermediate hash H(i-1).
- output_base_addr  input  ADDR_WIDTH  memory address for word 0.
- mem_write_en  output  1  write strobe, one word per cycle.
- mem_address  output  ADDR_WIDTH  write address.
- mem_write_data  output  32  write data.
- updated_hash_vector  output  256  H(i) = prev_hash_vector + hash_vector, word-wise.
- busy  output  1  high in WRITE.
- write_complete  output  1  high in DONE.

## Operation

- States: IDLE, WRITE, DONE. Reset puts the block in IDLE.
- IDLE: a start occurs when enable and hash_vector_complete are both high at a clock edge.
  - On the start edge, updated_hash_vector takes the word-wise sums for all words. Each sum is truncated to 32 bits; the carry is discarded and never crosses word boundaries.
  - The word index is cleared to 0 and the state becomes WRITE.
- WRITE: at each edge, while the index is below HASH_LENGTH, the outputs are registered as follows:
  - mem_write_en = 1.
  - mem_address = (output_base_addr + index) mod 2^ADDR_WIDTH. The address wraps; no saturation.
  - mem_write_data = updated_hash_vector word[index].
  - The index then increments.
- When the index reaches HASH_LENGTH, the next edge does the following:
  - Drives mem_write_en = 0 and sets write_complete = 1.
  - Changes the state to DONE.
- DONE: write_complete holds high.
  - A held-high hash_vector_complete does not retrigger.
  - The block returns to IDLE only when enable goes low. write_complete clears on that edge.
- enable low in any state, sampled at an edge:
  - State goes to IDLE and the index goes to 0.
  - mem_write_en, busy and write_complete go to 0.
  - updated_hash_vector is retained.
  - Writes already issued are not retracted.
- output_base_addr, hash_vector and prev_hash_vector are sampled as follows:
  - hash_vector and prev_hash_vector are used only on the start edge.
  - output_base_addr is used live during WRITE and must be held stable by the source.
- Reset values (async, reset = 0): all outputs 0, including mem_address, mem_write_data and updated_hash_vector. State is IDLE and the index is 0.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- Edge E0 (start): updated_hash_vector is valid after E0.
- Edges E1..E8: word k = 0..7 is presented after edge E(k+1). mem_write_en is high for exactly 8 consecutive cycles, with no gaps.
- Edge E9: mem_write_en falls and write_complete rises. Latency from start edge to write_complete is 9 cycles.
- busy is high from after E0 until E9.
- enable falling at an edge during WRITE: mem_write_en is 0 after that edge. No further words are written.
- Reset asserted mid-operation clears all outputs immediately, without waiting for a clock.
- Reset deassertion is synchronized externally. The first start is accepted at the first edge after release.

## Test plan

- Reset check: assert reset = 0 with random inputs.
  - Required: all outputs 0 immediately, state IDLE, and no mem_write_en for 20 cycles with enable = 0.
- Nominal with wrap: prev word i = 0xFFFFFFF0+i, hash word i = 0x00000020, base = 0x0100.
  - Required: start edge is +0; writes appear after edges +1..+8.
  - Addresses 0x0100..0x0107 and data 0x00000010..0x00000017.
  - updated_hash_vector matches the same words; write_complete is high after edge +9.
- Address wrap: base = 0xFFFC, ADDR_WIDTH = 16.
  - Required: addresses 0xFFFC, 0xFFFD, 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x0002, 0x0003.
- Abort: drop enable during the cycle word 3 is presented.
  - Required: only words 0..3 are written, mem_write_en is 0 after the next edge, write_complete stays 0, and updated_hash_vector is retained.
- No retrigger, then restart: hold hash_vector_complete high through DONE for 10 cycles.
  - Required: no extra writes.
  - Then drop enable for 1 cycle and re-raise it with new vectors.
  - Required: a second full 8-word burst with the new sums.
- Async reset mid-WRITE: pull reset low between edges during word 5.
  - Required: mem_write_en drops with no clock edge, and after release there are no residual writes.
